hazard_scoreboard: RTL and testbench

Parametrised hazard and bypass-control unit for the in-order pipeline, sitting beside the ID stage. A per-register scoreboard tracks the youngest in-flight producer of each architectural register, where it sits in the post-ID pipeline and the stage at which its result first becomes bypassable. From that state it produces the ID-stage stall and per-source bypass selects. It generalises fixed load-use detection to any number of post-ID stages and any per-instruction result latency (ALU, load, multi-cycle units), and it keeps a stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 195 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and bypass-control unit that sits beside the ID stage of an in-order
// pipeline. A per-register scoreboard remembers the youngest in-flight producer
// of every architectural register: which post-ID stage it currently occupies
// (pos) and the first stage whose output carries its result (avail). From that
// state the block decides, for each ID source operand, whether to read the
// register file, bypass from a stage, or stall ID. It also counts stall cycles.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   id_valid      ID holds a real instruction
//   id_rs1_s/rs2  source register indices
//   id_use_rs1/2  the corresponding source is actually read
//   id_rd_s       destination register index
//   id_regf_we    the ID instruction writes id_rd_s
//   id_avail      first stage index whose output carries the result
//   pipe_adv      whole pipeline advances this cycle (0 = backend freeze)
//   flush         kill the ID instruction
//   hazard_stall  hold PC/IF/ID and insert a bubble into EX
//   rs1_fwd_sel   0 = register file, k = bypass from stage k-1
//   rs2_fwd_sel   as rs1_fwd_sel, for the second source
//   stall_count   saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int NUM_STAGES = 3,
    parameter int STG_W      = $clog2(NUM_STAGES),
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1_s,
    input  logic [ADDR_W-1:0] id_rs2_s,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd_s,
    input  logic              id_regf_we,
    input  logic [STG_W-1:0]  id_avail,
    input  logic              pipe_adv,
    input  logic              flush,
    output logic              hazard_stall,
    output logic [SEL_W-1:0]  rs1_fwd_sel,
    output logic [SEL_W-1:0]  rs2_fwd_sel,
    output logic [31:0]       stall_count
);

    // Index of the last post-ID stage (WB); a producer there retires next advance.
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

    // Scoreboard: one entry per architectural register. Entry 0 is kept empty.
    logic             valid_q [NUM_REGS];
    logic             valid_d [NUM_REGS];
    logic [STG_W-1:0] pos_q   [NUM_REGS];
    logic [STG_W-1:0] pos_d   [NUM_REGS];
    logic [STG_W-1:0] avail_q [NUM_REGS];
    logic [STG_W-1:0] avail_d [NUM_REGS];

    logic [31:0]      stall_count_q;
    logic [31:0]      stall_count_d;

    logic             rs1_stall;
    logic             rs2_stall;
    logic             issue;
    logic [STG_W-1:0] avail_clamped;

    // Resolve one source operand against its scoreboard entry. A producer whose
    // result is already available (pos >= avail) is bypassed from stage pos,
    // which is select pos+1; otherwise the consumer must wait in ID.
    function automatic void check_src(
        input  logic             in_use,
        input  logic             ent_valid,
        input  logic [STG_W-1:0] ent_pos,
        input  logic [STG_W-1:0] ent_avail,
        output logic             src_stall,
        output logic [SEL_W-1:0] src_sel
    );
        src_stall = 1'b0;
        src_sel   = '0;
        if (in_use && ent_valid) begin
            if (ent_pos >= ent_avail) begin
                src_sel = SEL_W'(ent_pos) + SEL_W'(1);
            end else begin
                src_stall = 1'b1;
            end
        end
    endfunction

    // ------------------------------------------------------------------------
    // Source checks, stall and issue. These look at the scoreboard as it stands
    // before this cycle's insertion, so an instruction whose rd equals one of
    // its sources sees the older producer.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        rs1_stall     = 1'b0;
        rs2_stall     = 1'b0;
        rs1_fwd_sel   = '0;
        rs2_fwd_sel   = '0;
        avail_clamped = id_avail;

        check_src(id_valid && id_use_rs1 && (id_rs1_s != '0),
                  valid_q[id_rs1_s], pos_q[id_rs1_s], avail_q[id_rs1_s],
                  rs1_stall, rs1_fwd_sel);
        check_src(id_valid && id_use_rs2 && (id_rs2_s != '0),
                  valid_q[id_rs2_s], pos_q[id_rs2_s], avail_q[id_rs2_s],
                  rs2_stall, rs2_fwd_sel);

        // A redirect kills the ID instruction, so it must never hold the front end.
        hazard_stall = (rs1_stall | rs2_stall) & ~flush;

        issue = id_valid & id_regf_we & (id_rd_s != '0) & ~hazard_stall
              & ~flush & pipe_adv;

        // A result can never appear later than WB.
        if (id_avail > LAST_STG) begin
            avail_clamped = LAST_STG;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state: advance/retire every producer on pipe_adv, then
    // overwrite the destination entry on issue (the new producer is youngest).
    // ------------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            valid_d[r] = valid_q[r];
            pos_d[r]   = pos_q[r];
            avail_d[r] = avail_q[r];
        end

        if (pipe_adv) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (valid_q[r]) begin
                    if (pos_q[r] == LAST_STG) begin
                        valid_d[r] = 1'b0;
                    end else begin
                        pos_d[r] = pos_q[r] + STG_W'(1);
                    end
                end
            end
        end

        if (issue) begin
            valid_d[id_rd_s] = 1'b1;
            pos_d[id_rd_s]   = '0;
            avail_d[id_rd_s] = avail_clamped;
        end

        // Register 0 is hardwired zero and never tracked.
        valid_d[0] = 1'b0;
    end

    // Stall counter: counts only cycles in which the stall actually costs a
    // pipeline slot (a frozen pipeline is not the scoreboard's fault).
    always_comb begin
        stall_count_d = stall_count_q;
        if (id_valid && hazard_stall && pipe_adv && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                valid_q[r] <= 1'b0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                valid_q[r] <= valid_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    // NOTE: pos/avail are only meaningful while the matching valid bit is set,
    // so they are left out of reset; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pos_q[r]   <= pos_d[r];
            avail_q[r] <= avail_d[r];
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed table of per-cycle vectors, hand-written sequences for reset and
// counter saturation, then randomized traffic checked against a model that
// tracks the post-ID pipeline as a row of instruction slots and resolves each
// source by searching for the youngest slot that writes it.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_STAGES = 3;
    localparam int STG_W      = 2;
    localparam int SEL_W      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1_s;
    logic [ADDR_W-1:0] id_rs2_s;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [ADDR_W-1:0] id_rd_s;
    logic              id_regf_we;
    logic [STG_W-1:0]  id_avail;
    logic              pipe_adv;
    logic              flush;
    logic              hazard_stall;
    logic [SEL_W-1:0]  rs1_fwd_sel;
    logic [SEL_W-1:0]  rs2_fwd_sel;
    logic [31:0]       stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_s     (id_rs1_s),
        .id_rs2_s     (id_rs2_s),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd_s      (id_rd_s),
        .id_regf_we   (id_regf_we),
        .id_avail     (id_avail),
        .pipe_adv     (pipe_adv),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .rs1_fwd_sel  (rs1_fwd_sel),
        .rs2_fwd_sel  (rs2_fwd_sel),
        .stall_count  (stall_count)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  av;
        logic        adv;
        logic        flush;
        logic        e_stall;
        logic [1:0]  e_sel1;
        logic [1:0]  e_sel2;
        logic [31:0] e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a row of pipeline slots -----------------
    logic        m_v  [NUM_STAGES];
    logic [4:0]  m_rd [NUM_STAGES];
    int          m_av [NUM_STAGES];
    logic [31:0] m_cnt;
    logic        m_stall;
    int          m_sel1;
    int          m_sel2;

    function automatic void model_src(input logic [4:0] s, input logic u,
                                      output logic stl, output int sel);
        stl = 1'b0;
        sel = 0;
        if (!id_valid || !u || s == 5'd0) return;
        // Slot 0 is EX, so the first match is the youngest producer.
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (m_v[k] && m_rd[k] == s) begin
                if (k >= m_av[k]) sel = k + 1;
                else              stl = 1'b1;
                return;
            end
        end
    endfunction

    task automatic model_eval();
        logic s1, s2;
        model_src(id_rs1_s, id_use_rs1, s1, m_sel1);
        model_src(id_rs2_s, id_use_rs2, s2, m_sel2);
        m_stall = (s1 | s2) & ~flush;
    endtask

    task automatic model_clock();
        logic iss;
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) m_v[k] = 1'b0;
            m_cnt = 32'd0;
        end else if (pipe_adv) begin
            if (id_valid && m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            iss = id_valid & id_regf_we & (id_rd_s != 5'd0) & ~m_stall & ~flush;
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                m_v[k]  = m_v[k-1];
                m_rd[k] = m_rd[k-1];
                m_av[k] = m_av[k-1];
            end
            m_v[0]  = iss;
            m_rd[0] = id_rd_s;
            m_av[0] = (int'(id_avail) > NUM_STAGES - 1) ? NUM_STAGES - 1 : int'(id_avail);
        end
    endtask

    // ---------------- stimulus helpers -----------------
    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic we, input logic [1:0] av, input logic adv,
                                input logic fl, input logic e_stall, input logic [1:0] e_sel1,
                                input logic [1:0] e_sel2, input logic [31:0] e_cnt);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.we = we; v.av = av; v.adv = adv; v.flush = fl;
        v.e_stall = e_stall; v.e_sel1 = e_sel1; v.e_sel2 = e_sel2; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.valid = ($urandom % 8) != 0;
        v.rs1   = 5'($urandom % 8);
        v.u1    = ($urandom % 4) != 0;
        v.rs2   = 5'($urandom % 8);
        v.u2    = ($urandom % 2) != 0;
        v.rd    = 5'($urandom % 8);
        v.we    = ($urandom % 4) != 0;
        v.av    = 2'($urandom % 4);
        v.adv   = ($urandom % 5) != 0;
        v.flush = ($urandom % 10) == 0;
        v.e_stall = 1'b0; v.e_sel1 = '0; v.e_sel2 = '0; v.e_cnt = '0;
        return v;
    endfunction

    // Drive one cycle of inputs (just after a falling edge), compare outputs,
    // then let the rising edge happen and step the model.
    task automatic run(input vec_t v, input string tag, input bit use_model);
        logic        x_stall;
        logic [1:0]  x_sel1, x_sel2;
        logic [31:0] x_cnt;
        id_valid = v.valid; id_rs1_s = v.rs1; id_use_rs1 = v.u1;
        id_rs2_s = v.rs2; id_use_rs2 = v.u2; id_rd_s = v.rd;
        id_regf_we = v.we; id_avail = v.av; pipe_adv = v.adv; flush = v.flush;
        #1;
        model_eval();
        if (use_model) begin
            x_stall = m_stall; x_sel1 = 2'(m_sel1); x_sel2 = 2'(m_sel2); x_cnt = m_cnt;
        end else begin
            x_stall = v.e_stall; x_sel1 = v.e_sel1; x_sel2 = v.e_sel2; x_cnt = v.e_cnt;
        end
        check({tag, " stall"},   32'(hazard_stall), 32'(x_stall));
        check({tag, " rs1_sel"}, 32'(rs1_fwd_sel),  32'(x_sel1));
        check({tag, " rs2_sel"}, 32'(rs2_fwd_sel),  32'(x_sel2));
        check({tag, " count"},   stall_count,       x_cnt);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    vec_t tbl [27];
    vec_t idle;

    initial begin
        //           vld rs1 u1 rs2 u2 rd we av adv fl | stall s1 s2 cnt
        tbl[0]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 1, 0,   0, 0, 0, 0); // ALU x5
        tbl[1]  = mk(1,  5, 1,  0, 0,  6, 1, 0, 1, 0,   0, 1, 0, 0); // x5 from EX
        tbl[2]  = mk(1,  5, 1,  6, 1,  0, 0, 0, 1, 0,   0, 2, 1, 0);
        tbl[3]  = mk(1,  5, 1,  6, 1,  0, 0, 0, 1, 0,   0, 3, 2, 0);
        tbl[4]  = mk(1,  5, 1,  6, 1,  0, 0, 0, 1, 0,   0, 0, 3, 0); // x5 retired
        tbl[5]  = mk(1,  0, 0,  0, 0,  7, 1, 1, 1, 0,   0, 0, 0, 0); // load x7
        tbl[6]  = mk(1,  1, 0,  7, 1,  8, 1, 0, 1, 0,   1, 0, 0, 0); // load-use
        tbl[7]  = mk(1,  1, 0,  7, 1,  8, 1, 0, 1, 0,   0, 0, 2, 1);
        tbl[8]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 1);
        tbl[9]  = mk(1,  0, 0,  0, 0,  9, 1, 2, 1, 0,   0, 0, 0, 1); // mul x9
        tbl[10] = mk(1,  9, 1,  0, 0,  0, 0, 0, 1, 0,   1, 0, 0, 1);
        tbl[11] = mk(1,  9, 1,  0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 2); // freeze
        tbl[12] = mk(1,  9, 1,  0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 2);
        tbl[13] = mk(1,  9, 1,  0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 2);
        tbl[14] = mk(1,  9, 1,  0, 0,  0, 0, 0, 1, 0,   1, 0, 0, 2);
        tbl[15] = mk(1,  9, 1,  0, 0,  0, 0, 0, 1, 0,   0, 3, 0, 3);
        tbl[16] = mk(1,  0, 0,  0, 0,  3, 1, 1, 1, 0,   0, 0, 0, 3); // load x3
        tbl[17] = mk(1,  0, 0,  0, 0,  3, 1, 0, 1, 0,   0, 0, 0, 3); // ALU x3
        tbl[18] = mk(1,  3, 1,  0, 0,  0, 0, 0, 1, 0,   0, 1, 0, 3);
        tbl[19] = mk(1,  0, 0,  3, 1,  0, 0, 0, 1, 0,   0, 0, 2, 3);
        tbl[20] = mk(1,  0, 0,  0, 0,  0, 1, 2, 1, 0,   0, 0, 0, 3); // writes x0
        tbl[21] = mk(1,  0, 1,  0, 1,  0, 0, 0, 1, 0,   0, 0, 0, 3);
        tbl[22] = mk(1,  0, 0,  0, 0, 10, 1, 1, 1, 0,   0, 0, 0, 3); // load x10
        tbl[23] = mk(1, 10, 1,  0, 0, 11, 1, 0, 1, 1,   0, 0, 0, 3); // flushed
        tbl[24] = mk(1, 11, 1, 10, 1,  0, 0, 0, 1, 0,   0, 0, 2, 3);
        tbl[25] = mk(1, 10, 1,  0, 0, 10, 1, 0, 1, 0,   0, 3, 0, 3); // rd == rs
        tbl[26] = mk(1, 10, 1,  0, 0,  0, 0, 0, 1, 0,   0, 1, 0, 3);
        idle    = mk(0,  0, 0,  0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);

        // Reset.
        rst = 1'b1;
        id_valid = 0; id_rs1_s = 0; id_rs2_s = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd_s = 0; id_regf_we = 0; id_avail = 0; pipe_adv = 0; flush = 0;
        m_cnt = 0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            m_v[k] = 1'b0; m_rd[k] = '0; m_av[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 27; i++) begin
            run(tbl[i], $sformatf("tbl%0d", i), 1'b0);
        end

        // Reset while three producers are in flight, with the pipeline frozen.
        run(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3), "rst_seq0", 1'b0);
        run(mk(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 3), "rst_seq1", 1'b0);
        run(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 3), "rst_seq2", 1'b0);
        rst = 1'b1;
        run(mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 3), "rst_seq3", 1'b0);
        rst = 1'b0;
        run(mk(1, 1, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rst_seq4", 1'b0);
        run(mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rst_seq5", 1'b0);

        // Saturation: preload the counter just below its maximum. id_avail = 3
        // also exercises the clamp to WB (behaves like avail 2).
        force dut.stall_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_count_q;
        m_cnt = 32'hFFFF_FFFD;
        run(mk(1, 0, 0, 0, 0, 4, 1, 3, 1, 0, 0, 0, 0, 32'hFFFF_FFFD), "sat0", 1'b0);
        run(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFD), "sat1", 1'b0);
        run(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFE), "sat2", 1'b0);
        run(mk(1, 4, 1, 0, 0, 4, 1, 3, 1, 0, 0, 3, 0, 32'hFFFF_FFFF), "sat3", 1'b0);
        run(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFF), "sat4", 1'b0);
        run(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFF), "sat5", 1'b0);
        run(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 3, 32'hFFFF_FFFF), "sat6", 1'b0);

        // Randomized traffic against the slot model, with occasional resets.
        rst = 1'b1;
        run(idle, "rnd_rst", 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 100) == 0;
            run(rand_vec(), $sformatf("rnd%0d", i), 1'b1);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
